fb_write_arbiter: RTL and testbench
===================================

Name: fb_write_arbiter

Overview:
Shares the monochrome framebuffer's single write port among NUM_REQ independent requesters (pattern writer, text renderer, sprite blitter, ...). Arbitration is round-robin. The block drives the framebuffer we/w_xpos/w_ypos/din signals, waits for w_data_valid, and returns a one-cycle ack (or nack on timeout) to the granted requester. It sits between the top-level content generators and framebuffer_monochrome; the SSD1309 read side is untouched.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
COORD_W, 8, width of x/y position
DATA_W, 8, pixel byte width (8 pixels, 1 bit each)
TIMEOUT, 1023, max cycles to wait for fb_w_data_valid; 0 disables timeout

Ports:
clk  in  1  system clock (27 MHz)
rst_n  in  1  asynchronous reset, active low
req  in  NUM_REQ  per-requester write request, level; held until ack/nack
req_xpos  in  NUM_REQ*COORD_W  flat bus, slice i = requester i x position
req_ypos  in  NUM_REQ*COORD_W  flat bus, y positions
req_din  in  NUM_REQ*DATA_W  flat bus, pixel bytes
ack  out  NUM_REQ  one-cycle pulse: write committed
nack  out  NUM_REQ  one-cycle pulse: write abandoned on timeout
grant_id  out  $clog2(NUM_REQ)  index of current/last grantee
arb_busy  out  1  high while a transaction is outstanding
timeout_flag  out  1  sticky; set on any timeout, cleared only by reset
fb_busy  in  1  framebuffer busy
fb_we  out  1  framebuffer write enable
fb_w_xpos  out  COORD_W  framebuffer write x
fb_w_ypos  out  COORD_W  framebuffer write y
fb_din  out  DATA_W  framebuffer write data
fb_w_data_valid  in  1  framebuffer write done

Behaviour:
- Reset (rst_n low, async): all outputs 0, state IDLE, rr_ptr=0, timer=0, timeout_flag=0. All outputs are registered.
- States: IDLE, WRITE, GAP.
- IDLE:
  - If fb_busy=0 and any req bit is set, pick the first set bit scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Register the grantee's x/y/din onto the fb_* outputs, set fb_we=1, grant_id=g, arb_busy=1, timer=0, then go to WRITE.
  - fb_we rises one cycle after the req is seen.
  - If fb_busy=1, stay in IDLE and issue nothing.
- WRITE:
  - fb_we and fb_* data are held constant. Requester inputs are not re-sampled.
  - On fb_w_data_valid=1: fb_we=0, ack[g]=1 for one cycle, rr_ptr=(g+1) mod NUM_REQ, go to GAP.
  - Else if TIMEOUT!=0 and timer==TIMEOUT: fb_we=0, nack[g]=1, timeout_flag=1, rr_ptr=(g+1) mod NUM_REQ, go to GAP.
  - Else timer+1.
  - If data_valid and timeout coincide, data_valid wins (ack, no nack).
- GAP: exactly one cycle, arb_busy=0, then IDLE. The requester sees ack/nack and drops or updates req here, so the same transaction is never served twice. A back-to-back req from the same requester is legal and is re-arbitrated normally.
- Fairness: any continuously asserted req is granted within NUM_REQ transactions.
- A requester dropping req while granted (protocol violation) does not abort the write; the ack is still issued.
- fb_w_data_valid outside WRITE is ignored.
- Timer width: $clog2(TIMEOUT+1); saturating, no wrap.
- Reset mid-WRITE: fb_we drops asynchronously, no ack/nack issued, rr_ptr returns to 0.

Decomposition:
- Package fb_arb_pkg: state encoding (IDLE/WRITE/GAP), localparams for grant-index width and timer width, and a function to slice flat buses.
- One sub-module, rr_arbiter: combinational pick (req, rr_ptr -> grant one-hot + index + any). The pointer register stays in the parent.

Test Plan:
- Single request: req[1]=1, x=16, y=5, din=8'hA5; the stub framebuffer raises w_data_valid 3 cycles after fb_we -> fb_we high 1 cycle after req, fb_w_xpos=16, fb_w_ypos=5, fb_din=A5, one ack[1] pulse, grant_id=1.
- Contention: req[0], req[2], req[3] asserted together from reset -> grants in order 0, 2, 3. Then req[0] is reasserted while req[3] is pending -> 3 is served before 0. No grantee is ever served twice per transaction.
- fb_busy=1 for 50 cycles with req[0] high -> fb_we stays 0 throughout; fb_we rises the cycle after fb_busy falls.
- Timeout: TIMEOUT=15, the stub never asserts valid -> fb_we drops after 16 WRITE cycles, nack[g] pulses once, timeout_flag=1 and stays 1, and the next requester is then served normally.
- Reset mid-WRITE: pull rst_n low during WRITE -> fb_we=0 immediately, no ack, rr_ptr=0. After release with req[3:0]=4'b1111, requester 0 is granted first.
- Coincidence: fb_w_data_valid arrives on the same cycle the timer reaches TIMEOUT -> ack asserted, nack not asserted, timeout_flag stays 0.

Source files
------------

// File: rtl/fb_arb_pkg.sv
// Shared types and helpers for the framebuffer write-port arbiter.
// State encoding, default sizing and flat-bus field extraction.
package fb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_e;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_TIMEOUT = 1023;
    localparam int DEF_GRANT_W = $clog2(DEF_NUM_REQ);

    // Upper bounds for the generic field extractor: 8 requesters x 32-bit fields.
    localparam int MAX_BUS_W   = 256;
    localparam int MAX_FIELD_W = 32;

    // A timeout of 0 disables the timer, but the counter still needs one bit to exist.
    function automatic int timer_w(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

    function automatic logic [MAX_FIELD_W-1:0] slice_field(
        input logic [MAX_BUS_W-1:0] bus,
        input int                   idx,
        input int                   w
    );
        return MAX_FIELD_W'(bus >> (idx * w));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after rr_ptr, wrapping.
// The pointer register lives in the parent so it only advances on completion.
module rr_arbiter
    import fb_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int GRANT_W = DEF_GRANT_W
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] rr_ptr,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic [GRANT_W-1:0] grant_idx,
    output logic               grant_any
);

    int                 cand;
    logic [GRANT_W-1:0] cand_idx;

    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        grant_any    = 1'b0;
        cand         = 0;
        cand_idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = GRANT_W'(cand);
            if (!grant_any && req[cand_idx]) begin
                grant_any              = 1'b1;
                grant_idx              = cand_idx;
                grant_onehot[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter sharing the monochrome framebuffer write port among
// NUM_REQ content generators; returns a one-cycle ack, or nack on timeout.
module fb_write_arbiter
    import fb_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int COORD_W = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*COORD_W-1:0]   req_xpos,
    input  logic [NUM_REQ*COORD_W-1:0]   req_ypos,
    input  logic [NUM_REQ*DATA_W-1:0]    req_din,
    output logic [NUM_REQ-1:0]           ack,
    output logic [NUM_REQ-1:0]           nack,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         arb_busy,
    output logic                         timeout_flag,
    input  logic                         fb_busy,
    output logic                         fb_we,
    output logic [COORD_W-1:0]           fb_w_xpos,
    output logic [COORD_W-1:0]           fb_w_ypos,
    output logic [DATA_W-1:0]            fb_din,
    input  logic                         fb_w_data_valid
);

    localparam int                 GRANT_W    = $clog2(NUM_REQ);
    localparam int                 TIMER_W    = timer_w(TIMEOUT);
    localparam logic [GRANT_W-1:0] LAST_IDX   = GRANT_W'(NUM_REQ - 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX  = TIMER_W'(TIMEOUT);
    localparam bit                 TIMEOUT_EN = (TIMEOUT != 0);

    arb_state_e         state;
    logic [GRANT_W-1:0] rr_ptr;
    logic [TIMER_W-1:0] timer;
    logic [NUM_REQ-1:0] grant_oh;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [GRANT_W-1:0] pick_idx;
    logic               pick_any;
    logic [GRANT_W-1:0] ptr_after_grant;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .GRANT_W (GRANT_W)
    ) u_rr_arbiter (
        .req          (req),
        .rr_ptr       (rr_ptr),
        .grant_onehot (pick_onehot),
        .grant_idx    (pick_idx),
        .grant_any    (pick_any)
    );

    assign ptr_after_grant = (grant_id == LAST_IDX) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            timer        <= '0;
            grant_oh     <= '0;
            ack          <= '0;
            nack         <= '0;
            grant_id     <= '0;
            arb_busy     <= 1'b0;
            timeout_flag <= 1'b0;
            fb_we        <= 1'b0;
            fb_w_xpos    <= '0;
            fb_w_ypos    <= '0;
            fb_din       <= '0;
        end else begin
            ack  <= '0;
            nack <= '0;
            case (state)
                ST_IDLE: begin
                    if (!fb_busy && pick_any) begin
                        fb_w_xpos <= COORD_W'(slice_field(MAX_BUS_W'(req_xpos), int'(pick_idx), COORD_W));
                        fb_w_ypos <= COORD_W'(slice_field(MAX_BUS_W'(req_ypos), int'(pick_idx), COORD_W));
                        fb_din    <= DATA_W'(slice_field(MAX_BUS_W'(req_din), int'(pick_idx), DATA_W));
                        fb_we     <= 1'b1;
                        grant_id  <= pick_idx;
                        grant_oh  <= pick_onehot;
                        arb_busy  <= 1'b1;
                        timer     <= '0;
                        state     <= ST_WRITE;
                    end
                end
                // Requester inputs are deliberately not looked at here: the
                // write in flight is whatever was captured at grant time.
                ST_WRITE: begin
                    if (fb_w_data_valid) begin
                        fb_we    <= 1'b0;
                        ack      <= grant_oh;
                        rr_ptr   <= ptr_after_grant;
                        arb_busy <= 1'b0;
                        state    <= ST_GAP;
                    end else if (TIMEOUT_EN && (timer == TIMER_MAX)) begin
                        fb_we        <= 1'b0;
                        nack         <= grant_oh;
                        timeout_flag <= 1'b1;
                        rr_ptr       <= ptr_after_grant;
                        arb_busy     <= 1'b0;
                        state        <= ST_GAP;
                    end else if (timer != '1) begin
                        timer <= timer + 1'b1;
                    end
                end
                // One idle cycle lets the requester retire req before re-arbitration.
                ST_GAP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed scoreboard bench for fb_write_arbiter with a stub framebuffer
// that answers fb_we with w_data_valid after a programmable delay.
module tb_fb_write_arbiter;

    localparam int NUM_REQ = 4;
    localparam int COORD_W = 8;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 15;
    localparam int BOUND   = 200;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b1;
    logic [NUM_REQ-1:0]         req = '0;
    logic [NUM_REQ*COORD_W-1:0] req_xpos = '0;
    logic [NUM_REQ*COORD_W-1:0] req_ypos = '0;
    logic [NUM_REQ*DATA_W-1:0]  req_din = '0;
    logic [NUM_REQ-1:0]         ack;
    logic [NUM_REQ-1:0]         nack;
    logic [1:0]                 grant_id;
    logic                       arb_busy;
    logic                       timeout_flag;
    logic                       fb_busy = 1'b0;
    logic                       fb_we;
    logic [COORD_W-1:0]         fb_w_xpos;
    logic [COORD_W-1:0]         fb_w_ypos;
    logic [DATA_W-1:0]          fb_din;
    logic                       fb_w_data_valid = 1'b0;

    typedef struct {
        int         id;
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] d;
        bit         nack;
    } txn_t;

    txn_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    bit   stub_en = 1'b1;
    int   stub_delay = 3;
    int   we_cnt = 0;

    fb_write_arbiter #(
        .NUM_REQ (NUM_REQ),
        .COORD_W (COORD_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req             (req),
        .req_xpos        (req_xpos),
        .req_ypos        (req_ypos),
        .req_din         (req_din),
        .ack             (ack),
        .nack            (nack),
        .grant_id        (grant_id),
        .arb_busy        (arb_busy),
        .timeout_flag    (timeout_flag),
        .fb_busy         (fb_busy),
        .fb_we           (fb_we),
        .fb_w_xpos       (fb_w_xpos),
        .fb_w_ypos       (fb_w_ypos),
        .fb_din          (fb_din),
        .fb_w_data_valid (fb_w_data_valid)
    );

    always #5 clk = ~clk;

    // Stub framebuffer: valid pulses when fb_we has been high for stub_delay cycles.
    always @(negedge clk) begin
        if (fb_we === 1'b1) we_cnt = we_cnt + 1;
        else                we_cnt = 0;
        fb_w_data_valid = stub_en && (fb_we === 1'b1) && (we_cnt == stub_delay);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] x, input logic [7:0] y,
                           input logic [7:0] d, input bit exp_nack, input bit push);
        txn_t t;
        req_xpos[i*COORD_W +: COORD_W] = x;
        req_ypos[i*COORD_W +: COORD_W] = y;
        req_din[i*DATA_W +: DATA_W]    = d;
        req[i] = 1'b1;
        t.id = i; t.x = x; t.y = y; t.d = d; t.nack = exp_nack;
        if (push) sb.push_back(t);
    endtask

    task automatic serve(input int exp_lat);
        txn_t t;
        int   n;
        int   hold_bad;
        n = 0;
        while (fb_we !== 1'b1 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check("fb_we_rise", fb_we, 1);
        t = sb.pop_front();
        check("grant_id", grant_id, t.id);
        check("fb_w_xpos", fb_w_xpos, t.x);
        check("fb_w_ypos", fb_w_ypos, t.y);
        check("fb_din", fb_din, t.d);
        check("arb_busy_write", arb_busy, 1);
        n = 0;
        hold_bad = 0;
        while (ack === '0 && nack === '0 && n < BOUND) begin
            if (fb_we !== 1'b1 || fb_w_xpos !== t.x || fb_din !== t.d) hold_bad++;
            @(negedge clk);
            n++;
        end
        check("write_hold", hold_bad, 0);
        check("write_latency", n, exp_lat);
        check("ack", ack, t.nack ? 0 : (1 << t.id));
        check("nack", nack, t.nack ? (1 << t.id) : 0);
        check("fb_we_drop", fb_we, 0);
        check("arb_busy_gap", arb_busy, 0);
        req[t.id] = 1'b0;
        @(negedge clk);
        check("ack_pulse", ack, 0);
        check("nack_pulse", nack, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_fb_we", fb_we, 0);
        check("rst_ack", ack, 0);
        check("rst_nack", nack, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_arb_busy", arb_busy, 0);
        check("rst_timeout_flag", timeout_flag, 0);
        check("rst_fb_w_xpos", fb_w_xpos, 0);
        check("rst_fb_din", fb_din, 0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int we_seen;
        #1 rst_n = 1'b0;
        do_reset();

        // Single request, valid three cycles after fb_we.
        stub_en = 1'b1;
        stub_delay = 3;
        set_req(1, 8'd16, 8'd5, 8'hA5, 1'b0, 1'b1);
        @(negedge clk);
        check("we_one_cycle_after_req", fb_we, 1);
        serve(3);

        // Contention from reset: 0, 2, 3; then 0 reasserted while 3 pending.
        do_reset();
        stub_delay = 2;
        set_req(0, 8'd10, 8'd20, 8'h11, 1'b0, 1'b1);
        set_req(2, 8'd30, 8'd40, 8'h22, 1'b0, 1'b1);
        set_req(3, 8'd50, 8'd60, 8'h33, 1'b0, 1'b1);
        serve(2);
        serve(2);
        set_req(0, 8'd70, 8'd80, 8'h44, 1'b0, 1'b1);
        serve(2);
        serve(2);

        // fb_busy holds off the grant.
        fb_busy = 1'b1;
        set_req(0, 8'd1, 8'd2, 8'h5A, 1'b0, 1'b1);
        we_seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (fb_we !== 1'b0) we_seen++;
        end
        check("busy_no_we", we_seen, 0);
        fb_busy = 1'b0;
        @(negedge clk);
        check("we_after_busy", fb_we, 1);
        serve(2);

        // Reset mid-WRITE: fb_we drops at once, pointer returns to 0.
        stub_en = 1'b0;
        set_req(1, 8'd9, 8'd9, 8'h99, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("mid_we_up", fb_we, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_we_drop", fb_we, 0);
        check("async_no_ack", ack, 0);
        check("async_no_nack", nack, 0);
        check("async_busy", arb_busy, 0);
        set_req(0, 8'd100, 8'd101, 8'hC0, 1'b0, 1'b1);
        set_req(1, 8'd110, 8'd111, 8'hC1, 1'b0, 1'b0);
        set_req(2, 8'd120, 8'd121, 8'hC2, 1'b0, 1'b0);
        set_req(3, 8'd130, 8'd131, 8'hC3, 1'b0, 1'b0);
        @(negedge clk);
        stub_en = 1'b1;
        stub_delay = 2;
        rst_n = 1'b1;
        serve(2);
        req = '0;
        @(negedge clk);

        // Valid on the same cycle the timer reaches TIMEOUT: ack wins.
        stub_delay = TIMEOUT + 1;
        set_req(2, 8'd7, 8'd8, 8'h3C, 1'b0, 1'b1);
        serve(TIMEOUT + 1);
        check("coincide_no_flag", timeout_flag, 0);

        // Timeout: no valid ever, nack after TIMEOUT+1 WRITE cycles.
        stub_en = 1'b0;
        set_req(3, 8'd200, 8'd201, 8'hEE, 1'b1, 1'b1);
        serve(TIMEOUT + 1);
        check("timeout_flag_set", timeout_flag, 1);
        stub_en = 1'b1;
        stub_delay = 2;
        set_req(1, 8'd33, 8'd44, 8'h55, 1'b0, 1'b1);
        serve(2);
        check("timeout_flag_sticky", timeout_flag, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
